gsm_ingress_alloc: RTL and testbench

Per-port ingress allocation controller for the grouped-share-memory switch, running in the 80 MHz port domain. It prefetches free cell pointers from one hardware malloc pipe (HMP) port of the GSM unit and accepts cell descriptors from the ingress port logic. For each accepted cell it emits a one-cycle write command (enable, address, multicast vector) to the matching GSM unit ingress malloc port. It tracks cells resident in shared memory using the GSM unit's buffer-free flag, and back-pressures the port when its share is exhausted.

---
 rtl/gsm_ingress_alloc.sv | 160 ++++++++++++++++
 tb/tb_gsm_ingress_alloc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gsm_ingress_alloc.sv
// Per-port ingress allocation controller: HMP pointer prefetch, cell accept, GSM write command, in-flight credit.
// Optional statistics counters enabled by defining GSM_INGRESS_STATS_EN.
module gsm_ingress_alloc #(
    parameter int unsigned MWIDTH       = 4,
    parameter int unsigned AWIDTH       = 7,
    parameter int unsigned MAX_INFLIGHT = 128
) (
    input  logic              clk_80M,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_cell_valid,
    input  logic [MWIDTH-1:0] i_cell_multicast,
    output logic              o_cell_ready,
    output logic              o_wr_en,
    output logic [AWIDTH-1:0] o_wr_addr,
    output logic [MWIDTH-1:0] o_multicast,
    output logic              o_hmp_rd,
    input  logic              i_hmp_valid,
    input  logic [AWIDTH-1:0] i_hmp_addr,
    input  logic              i_bf_free_flag,
    output logic [AWIDTH:0]   o_inflight,
    output logic              o_err,
    output logic [15:0]       o_cell_cnt,
    output logic [15:0]       o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [AWIDTH:0] MAX_CNT = (AWIDTH+1)'(MAX_INFLIGHT);

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   ptr_mem_q [2];
    logic                rd_idx_q, rd_idx_d;
    logic [1:0]          ptr_cnt_q, ptr_cnt_d;
    logic                rd_pend_q;
    logic [AWIDTH:0]     inflight_q, inflight_d;
    logic                err_q, err_d;
    logic                wr_en_q;
    logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [MWIDTH-1:0]   mc_q, mc_d;

    logic                cell_ready;
    logic                accept;
    logic                hmp_rd;
    logic                wr_idx;
    logic [2:0]          fill_lvl;
    logic                free_err;
    logic                mc_err;

    always_comb begin
        cell_ready = (state_q == ST_RUN) && (ptr_cnt_q != 2'd0) && (inflight_q < MAX_CNT);
        accept     = i_cell_valid & cell_ready;
        // Pointers already cached plus one in flight from the HMP, minus the one leaving now.
        fill_lvl   = {1'b0, ptr_cnt_q} + {2'b00, rd_pend_q} - {2'b00, accept};
        hmp_rd     = rst_n & i_hmp_valid & (state_q != ST_HALT) & (fill_lvl < 3'd2);
        wr_idx     = rd_idx_q ^ ptr_cnt_q[0];
        free_err   = i_bf_free_flag & (inflight_q == '0);
        mc_err     = accept & (i_cell_multicast == '0);

        rd_idx_d   = accept ? ~rd_idx_q : rd_idx_q;
        ptr_cnt_d  = ptr_cnt_q + {1'b0, rd_pend_q} - {1'b0, accept};

        wr_addr_d  = wr_addr_q;
        mc_d       = mc_q;
        if (accept) begin
            wr_addr_d = ptr_mem_q[rd_idx_q];
            mc_d      = i_cell_multicast;
        end

        inflight_d = inflight_q;
        case ({accept, i_bf_free_flag})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        err_d   = err_q | free_err | mc_err;
        state_d = state_q;
        if (free_err || mc_err) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_IDLE: if (i_enable)  state_d = ST_RUN;
                ST_RUN:  if (!i_enable) state_d = ST_IDLE;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_mem_q[0] <= '0;
            ptr_mem_q[1] <= '0;
            rd_idx_q     <= 1'b0;
            ptr_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            inflight_q   <= '0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            mc_q         <= '0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            ptr_cnt_q  <= ptr_cnt_d;
            rd_pend_q  <= hmp_rd;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            wr_en_q    <= accept;
            wr_addr_q  <= wr_addr_d;
            mc_q       <= mc_d;
            // When full, the push slot is the head being popped this same cycle.
            if (rd_pend_q) ptr_mem_q[wr_idx] <= i_hmp_addr;
        end
    end

`ifdef GSM_INGRESS_STATS_EN
    logic [15:0] cell_cnt_q, cell_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        cell_cnt_d  = cell_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && cell_cnt_q != '1) cell_cnt_d = cell_cnt_q + 16'd1;
        if ((state_q == ST_RUN) && i_cell_valid && !cell_ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            cell_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            cell_cnt_q  <= cell_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_cell_cnt  = cell_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_cell_cnt  = '0;
    assign o_stall_cnt = '0;
`endif

    assign o_cell_ready = cell_ready;
    assign o_hmp_rd     = hmp_rd;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_multicast  = mc_q;
    assign o_inflight   = inflight_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_gsm_ingress_alloc.sv
// Randomized and directed bench for gsm_ingress_alloc against a queue-based behavioural model.
module tb_gsm_ingress_alloc;
    localparam int unsigned MW   = 4;
    localparam int unsigned AW   = 7;
    localparam int unsigned MAXI = 4;

    logic          clk_80M = 1'b0;
    logic          rst_n   = 1'b1;
    logic          i_enable = 1'b0, i_cell_valid = 1'b0, i_hmp_valid = 1'b0, i_bf_free_flag = 1'b0;
    logic [MW-1:0] i_cell_multicast = '0;
    logic [AW-1:0] i_hmp_addr = '0;
    logic          o_cell_ready, o_wr_en, o_hmp_rd, o_err;
    logic [AW-1:0] o_wr_addr;
    logic [MW-1:0] o_multicast;
    logic [AW:0]   o_inflight;
    logic [15:0]   o_cell_cnt, o_stall_cnt;

    gsm_ingress_alloc #(.MWIDTH(MW), .AWIDTH(AW), .MAX_INFLIGHT(MAXI)) dut (
        .clk_80M(clk_80M), .rst_n(rst_n), .i_enable(i_enable),
        .i_cell_valid(i_cell_valid), .i_cell_multicast(i_cell_multicast),
        .o_cell_ready(o_cell_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_multicast(o_multicast), .o_hmp_rd(o_hmp_rd), .i_hmp_valid(i_hmp_valid),
        .i_hmp_addr(i_hmp_addr), .i_bf_free_flag(i_bf_free_flag),
        .o_inflight(o_inflight), .o_err(o_err),
        .o_cell_cnt(o_cell_cnt), .o_stall_cnt(o_stall_cnt)
    );

    always #6 clk_80M = ~clk_80M;

    int unsigned n_cmp = 0, n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: spec-level mode, pointer cache queue, credit counter.
    typedef enum {M_IDLE, M_RUN, M_HALT} mmode_e;
    mmode_e        m_mode;
    logic [AW-1:0] m_cache[$];
    bit            m_pend;
    int            m_infl;
    bit            m_err, m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [MW-1:0] m_mc;
    int            m_cell, m_stall;

    // HMP stand-in: pointer queue, data presented the cycle after a pop.
    logic [AW-1:0] hmp_q[$];
    bit            hmp_out_pend;
    logic [AW-1:0] hmp_out;

    int            cyc = 0;
    logic [AW-1:0] wr_log[$];
    int            wr_cyc[$];

    task automatic model_reset();
        m_mode = M_IDLE; m_cache.delete(); m_pend = 0; m_infl = 0; m_err = 0;
        m_wr_en = 0; m_wr_addr = '0; m_mc = '0; m_cell = 0; m_stall = 0;
        hmp_out_pend = 0;
    endtask

    // Entered at a negedge; asserts reset mid-cycle and releases it at the next negedge.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_ready", o_cell_ready, 0);
        check("rst_wr_en", o_wr_en, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_mc", o_multicast, 0);
        check("rst_hmp_rd", o_hmp_rd, 0);
        check("rst_infl", o_inflight, 0);
        check("rst_err", o_err, 0);
        check("rst_cell_cnt", o_cell_cnt, 0);
        check("rst_stall_cnt", o_stall_cnt, 0);
        model_reset();
        wr_log.delete(); wr_cyc.delete();
        @(negedge clk_80M);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit en, input bit valid, input logic [MW-1:0] mc,
                        input bit free, input bit gate);
        bit exp_ready, acc, exp_rd, new_err;
        int exp_cc, exp_sc;
        i_enable = en; i_cell_valid = valid; i_cell_multicast = mc; i_bf_free_flag = free;
        i_hmp_valid = gate && (hmp_q.size() != 0);
        i_hmp_addr  = hmp_out_pend ? hmp_out : AW'($urandom);
        #1;
        exp_ready = (m_mode == M_RUN) && (m_cache.size() != 0) && (m_infl < int'(MAXI));
        acc       = valid && exp_ready;
        exp_rd    = i_hmp_valid && (m_mode != M_HALT) &&
                    (int'(m_cache.size()) + int'(m_pend) - int'(acc) < 2);
`ifdef GSM_INGRESS_STATS_EN
        exp_cc = m_cell; exp_sc = m_stall;
`else
        exp_cc = 0; exp_sc = 0;
`endif
        check("ready", o_cell_ready, exp_ready);
        check("hmp_rd", o_hmp_rd, exp_rd);
        check("wr_en", o_wr_en, m_wr_en);
        check("wr_addr", o_wr_addr, m_wr_addr);
        check("mc", o_multicast, m_mc);
        check("inflight", o_inflight, m_infl);
        check("err", o_err, m_err);
        check("cell_cnt", o_cell_cnt, exp_cc);
        check("stall_cnt", o_stall_cnt, exp_sc);
        if (o_wr_en) begin wr_log.push_back(o_wr_addr); wr_cyc.push_back(cyc); end

        new_err = 0;
        if (m_mode == M_RUN && valid && !exp_ready && m_stall < 65535) m_stall++;
        m_wr_en = acc;
        if (acc) begin
            m_wr_addr = m_cache.pop_front();
            m_mc = mc;
            if (m_cell < 65535) m_cell++;
            if (mc == '0) new_err = 1;
        end
        if (m_pend) m_cache.push_back(i_hmp_addr);
        if (free && m_infl == 0) new_err = 1;
        if (acc && !free) m_infl++;
        else if (free && !acc && m_infl > 0) m_infl--;
        if (new_err) begin
            m_err = 1; m_mode = M_HALT;
        end else if (m_mode == M_IDLE && en) m_mode = M_RUN;
        else if (m_mode == M_RUN && !en) m_mode = M_IDLE;
        m_pend = exp_rd;
        hmp_out_pend = exp_rd;
        if (exp_rd) hmp_out = hmp_q.pop_front();
        @(negedge clk_80M);
        cyc++;
    endtask

    initial begin
        int k, n;
        logic [MW-1:0] mc;
        bit fr;
        model_reset();
        @(negedge clk_80M);

        // Three back-to-back cells with pointers 05, 06, 07.
        do_reset();
        hmp_q = '{7'h05, 7'h06, 7'h07};
        for (int i = 0; i < 8; i++) step(1, 1, 4'b0011, 0, 1);
        check("tp1_nwr", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("tp1_a0", wr_log[0], 7'h05);
            check("tp1_a1", wr_log[1], 7'h06);
            check("tp1_a2", wr_log[2], 7'h07);
            check("tp1_consec", wr_cyc[2] - wr_cyc[0], 2);
        end
        check("tp1_infl", o_inflight, 3);

        // Credit limit of 4, then one free releases exactly one more write.
        do_reset();
        hmp_q.delete();
        for (int i = 0; i < 12; i++) hmp_q.push_back(AW'(8'h20 + i));
        for (int i = 0; i < 12; i++) step(1, 1, 4'b0101, 0, 1);
        check("tp2_nwr", wr_log.size(), 4);
        check("tp2_ready", o_cell_ready, 0);
        step(1, 1, 4'b0101, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 4'b0101, 0, 1);
        check("tp2_nwr_after", wr_log.size(), 5);

        // Accept and free in the same cycle at inflight 2.
        do_reset();
        hmp_q.delete();
        for (int i = 0; i < 8; i++) hmp_q.push_back(AW'(8'h30 + i));
        n = 0;
        while (!(m_infl == 2 && m_cache.size() != 0 && m_mode == M_RUN) && n < 20) begin
            step(1, m_infl < 2 && m_mode == M_RUN && m_cache.size() != 0, 4'b1000, 0, 1);
            n++;
        end
        check("tp3_setup", n < 20, 1);
        step(1, 1, 4'b1000, 1, 1);
        step(1, 0, 4'b1000, 0, 1);
        check("tp3_infl", o_inflight, 2);

        // HMP empty: no ready, no write; then pointer 0x10 arrives.
        do_reset();
        hmp_q.delete();
        for (int i = 0; i < 4; i++) step(1, 1, 4'b0010, 0, 1);
        check("tp4_nowr", wr_log.size(), 0);
        check("tp4_ready", o_cell_ready, 0);
        hmp_q.push_back(7'h10);
        k = cyc;
        for (int i = 0; i < 6; i++) step(1, 1, 4'b0010, 0, 1);
        check("tp4_nwr", wr_log.size(), 1);
        if (wr_log.size() == 1) begin
            check("tp4_addr", wr_log[0], 7'h10);
            check("tp4_lat", wr_cyc[0] - k, 3);
        end

        // Free at zero -> sticky error, HALT; then reset mid-burst.
        do_reset();
        hmp_q.delete();
        for (int i = 0; i < 6; i++) hmp_q.push_back(AW'(8'h40 + i));
        step(1, 0, 4'b0001, 0, 1);
        step(1, 0, 4'b0001, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 4'b0001, 0, 1);
        check("tp5_err", o_err, 1);
        check("tp5_ready", o_cell_ready, 0);
        check("tp5_nowr", wr_log.size(), 0);
        do_reset();
        for (int i = 0; i < 12; i++) hmp_q.push_back(AW'(8'h50 + i));
        for (int i = 0; i < 4; i++) step(1, 1, 4'b0110, 0, 1);
        do_reset();

        // Statistics: 5 stall cycles then 3 accepts.
        hmp_q.delete();
        step(1, 0, 4'b0001, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 4'b0001, 0, 1);
        hmp_q = '{7'h61, 7'h62, 7'h63};
        for (int i = 0; i < 4; i++) step(1, 0, 4'b0001, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 4'b0001, 0, 1);
        step(1, 0, 4'b0001, 0, 1);
`ifdef GSM_INGRESS_STATS_EN
        check("tp6_stall", o_stall_cnt, 5);
        check("tp6_cells", o_cell_cnt, 3);
`else
        check("tp6_stall", o_stall_cnt, 0);
        check("tp6_cells", o_cell_cnt, 0);
`endif
        check("tp6_nwr", wr_log.size(), 3);

        // Randomized phases.
        for (int p = 0; p < 15; p++) begin
            do_reset();
            hmp_q.delete();
            for (int c = 0; c < 200; c++) begin
                if (hmp_q.size() < 4)
                    for (int j = 0; j < 16; j++) hmp_q.push_back(AW'($urandom));
                mc = ($urandom_range(0, 99) == 0) ? '0 : MW'($urandom_range(1, 15));
                fr = (m_infl > 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 149) == 0);
                step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, mc, fr,
                     $urandom_range(0, 9) < 8);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
